// File: rtl/player_countdown.sv
// ---------------------------------------------------------------------------
// player_countdown : per-player BCD mm:ss chess-clock countdown (opt. INCREMENT_EN = Fischer increment)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module player_countdown #(
   parameter int TICKS_PER_SEC = 100,
   parameter int INIT_MIN      = 5,
   parameter int INIT_SEC      = 0,
   parameter int INC_SEC       = 2
) (
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       CE,
   input  logic       ACTIVE,
   input  logic       LOAD,
   input  logic       END,
   output logic [3:0] MIN_T,
   output logic [3:0] MIN_U,
   output logic [3:0] SEC_T,
   output logic [3:0] SEC_U,
   output logic       OVERFLOW,
   output logic       RUNNING
);

   localparam int             PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [3:0]     INIT_MT  = 4'(INIT_MIN / 10);
   localparam logic [3:0]     INIT_MU  = 4'(INIT_MIN % 10);
   localparam logic [3:0]     INIT_ST  = 4'(INIT_SEC / 10);
   localparam logic [3:0]     INIT_SU  = 4'(INIT_SEC % 10);

   if (TICKS_PER_SEC < 1 || TICKS_PER_SEC > 1023 || INIT_MIN < 0 || INIT_MIN > 99 ||
       INIT_SEC < 0 || INIT_SEC > 59 || INC_SEC < 0 || INC_SEC > 59 ||
       (INIT_MIN * 60 + INIT_SEC) < 1) begin : g_bad_params
      $error("player_countdown: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_HOLD    = 3'd2,
      ST_EXPIRED = 3'd3,
      ST_FROZEN  = 3'd4
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;

   logic [3:0] dec_mt, dec_mu, dec_st, dec_su;
   logic       dec_zero;

   // Borrow chain; 00:00 is held rather than wrapped.
   always_comb begin
      dec_mt = MIN_T;
      dec_mu = MIN_U;
      dec_st = SEC_T;
      dec_su = SEC_U;
      if ({MIN_T, MIN_U, SEC_T, SEC_U} != 16'h0000) begin
         if (SEC_U != 4'd0) begin
            dec_su = SEC_U - 4'd1;
         end else begin
            dec_su = 4'd9;
            if (SEC_T != 4'd0) begin
               dec_st = SEC_T - 4'd1;
            end else begin
               dec_st = 4'd5;
               if (MIN_U != 4'd0) begin
                  dec_mu = MIN_U - 4'd1;
               end else begin
                  dec_mu = 4'd9;
                  dec_mt = MIN_T - 4'd1;
               end
            end
         end
      end
      dec_zero = ({dec_mt, dec_mu, dec_st, dec_su} == 16'h0000);
   end

`ifdef INCREMENT_EN
   logic [3:0] inc_mt, inc_mu, inc_st, inc_su;
   logic [6:0] sec_bin, sec_sum, sec_new, min_bin, min_new;
   logic       sec_carry;

   // Binary add on the small fields, then back to BCD; saturates at 99:59.
   always_comb begin
      sec_bin   = 7'(SEC_T) * 7'd10 + 7'(SEC_U);
      sec_sum   = sec_bin + 7'(INC_SEC);
      sec_carry = (sec_sum >= 7'd60);
      sec_new   = sec_carry ? (sec_sum - 7'd60) : sec_sum;
      min_bin   = 7'(MIN_T) * 7'd10 + 7'(MIN_U);
      min_new   = min_bin + {6'd0, sec_carry};
      if (min_new > 7'd99) begin
         inc_mt = 4'd9;
         inc_mu = 4'd9;
         inc_st = 4'd5;
         inc_su = 4'd9;
      end else begin
         inc_mt = 4'(min_new / 7'd10);
         inc_mu = 4'(min_new % 7'd10);
         inc_st = 4'(sec_new / 7'd10);
         inc_su = 4'(sec_new % 7'd10);
      end
   end
`endif

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state    <= ST_IDLE;
         presc    <= '0;
         {MIN_T, MIN_U, SEC_T, SEC_U} <= {INIT_MT, INIT_MU, INIT_ST, INIT_SU};
         OVERFLOW <= 1'b0;
         RUNNING  <= 1'b0;
      end else if (LOAD) begin
         state    <= ST_IDLE;
         presc    <= '0;
         {MIN_T, MIN_U, SEC_T, SEC_U} <= {INIT_MT, INIT_MU, INIT_ST, INIT_SU};
         OVERFLOW <= 1'b0;
         RUNNING  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HOLD: begin
               if (END) begin
                  state <= ST_FROZEN;
               end else if (ACTIVE) begin
                  state   <= ST_RUN;
                  RUNNING <= 1'b1;
               end
            end
            ST_RUN: begin
               if (END) begin
                  state   <= ST_FROZEN;
                  RUNNING <= 1'b0;
               end else if (!ACTIVE) begin
                  state   <= ST_HOLD;
                  RUNNING <= 1'b0;
`ifdef INCREMENT_EN
                  {MIN_T, MIN_U, SEC_T, SEC_U} <= {inc_mt, inc_mu, inc_st, inc_su};
`endif
               end else if (CE) begin
                  if (presc == PRE_LAST) begin
                     presc <= '0;
                     {MIN_T, MIN_U, SEC_T, SEC_U} <= {dec_mt, dec_mu, dec_st, dec_su};
                     if (dec_zero) begin
                        state    <= ST_EXPIRED;
                        OVERFLOW <= 1'b1;
                        RUNNING  <= 1'b0;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
            end
            ST_EXPIRED, ST_FROZEN: begin
               state <= state;
            end
            default: begin
               state   <= ST_IDLE;
               RUNNING <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
